regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp_pkg.sv | 13 +
 rtl/regfile_mp_sb.sv | 40 ++++
 rtl/regfile_mp.sv | 117 +++++++++++
 tb/tb_regfile_mp.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared types and helpers for the multi-port register file with issue scoreboard.
package regfile_mp_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_t;

    function automatic int calc_aw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_mp_sb.sv
// Pending-bit scoreboard: issue marks a register busy, a committed write frees it.
module regfile_mp_sb
    import regfile_mp_pkg::*;
#(
    parameter int NREG = 32,
    parameter int NWP  = 2,
    localparam int AW  = calc_aw(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              flush,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_addr,
    input  logic [NWP-1:0]    wr_en,
    input  logic [NWP*AW-1:0] wr_addr,
    output logic [NREG-1:0]   pending
);

    logic [NREG-1:0] pend_nx;

    // Issue is applied after write clears so it wins on a same-register collision.
    always_comb begin
        pend_nx = pending;
        if (run) begin
            for (int w = 0; w < NWP; w++) begin
                if (wr_en[w]) pend_nx[wr_addr[w*AW +: AW]] = 1'b0;
            end
            if (iss_valid) pend_nx[iss_addr] = 1'b1;
        end
        pend_nx[0] = 1'b0;
        if (flush || !run) pend_nx = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) pending <= '0;
        else        pending <= pend_nx;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with zero-latency reads, optional write forwarding,
// pending-bit scoreboard and a one-register-per-cycle clear walk.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRP    = 2,
    parameter int NWP    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = calc_aw(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]      rd_pending,
    input  logic [NWP-1:0]      wr_en,
    input  logic [NWP*AW-1:0]   wr_addr,
    input  logic [NWP*XLEN-1:0] wr_data,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_addr,
    input  logic                clr_req,
    output logic                ready,
    output rf_state_t           dbg_state
);

    rf_state_t       state, state_nx;
    logic [AW-1:0]   idx, idx_nx;
    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] pending;
    logic            run;
    logic            flush;

    assign run       = (state == ST_RUN);
    assign flush     = run && clr_req;
    assign ready     = run;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_CLEAR;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            ST_CLEAR: begin
                idx_nx = idx + AW'(1);
                if (idx == AW'(NREG - 1)) state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (clr_req) begin
                    state_nx = ST_CLEAR;
                    idx_nx   = '0;
                end
            end
            default: begin
                state_nx = ST_CLEAR;
                idx_nx   = '0;
            end
        endcase
    end

    // Later ports are assigned last, so the highest-index port wins a collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == ST_CLEAR) begin
                mem[idx] <= '0;
            end else begin
                for (int w = 0; w < NWP; w++) begin
                    if (wr_en[w] && (wr_addr[w*AW +: AW] != '0))
                        mem[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        rd_data    = '0;
        rd_pending = '0;
        for (int p = 0; p < NRP; p++) begin
            if (run && (rd_addr[p*AW +: AW] != '0)) begin
                rd_data[p*XLEN +: XLEN] = mem[rd_addr[p*AW +: AW]];
                if (BYPASS != 0) begin
                    for (int w = 0; w < NWP; w++) begin
                        if (wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW]))
                            rd_data[p*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
                    end
                end
                rd_pending[p] = pending[rd_addr[p*AW +: AW]];
            end
        end
    end

    regfile_mp_sb #(
        .NREG (NREG),
        .NWP  (NWP)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .flush     (flush),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .pending   (pending)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios plus randomized traffic against an
// array/queue-level reference model; a BYPASS=0 twin shares all inputs.
module tb_regfile_mp;
    import regfile_mp_pkg::*;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRP  = 2;
    localparam int NWP  = 2;
    localparam int AW   = 5;

    logic                clk;
    logic                reset;
    logic [NRP*AW-1:0]   rd_addr;
    logic [NRP*XLEN-1:0] rd_data0, rd_data1;
    logic [NRP-1:0]      rd_pending0, rd_pending1;
    logic [NWP-1:0]      wr_en;
    logic [NWP*AW-1:0]   wr_addr;
    logic [NWP*XLEN-1:0] wr_data;
    logic                iss_valid;
    logic [AW-1:0]       iss_addr;
    logic                clr_req;
    logic                ready0, ready1;
    rf_state_t           dbg_state0, dbg_state1;

    int checks_passed = 0;
    int checks_total  = 0;

    // reference model
    logic [XLEN-1:0] m_mem [NREG];
    bit              m_pend [NREG];
    bit              m_run;
    int              m_clr_cnt;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data0),
        .rd_pending(rd_pending0), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .clr_req(clr_req),
        .ready(ready0), .dbg_state(dbg_state0)
    );

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data1),
        .rd_pending(rd_pending1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .clr_req(clr_req),
        .ready(ready1), .dbg_state(dbg_state1)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    // model update on every rising edge, using the inputs held across that edge
    task automatic model_edge();
        if (!reset) begin
            m_run = 0;
            m_clr_cnt = 0;
            for (int i = 0; i < NREG; i++) m_pend[i] = 0;
        end else if (!m_run) begin
            m_mem[m_clr_cnt] = '0;
            m_clr_cnt++;
            if (m_clr_cnt == NREG) m_run = 1;
        end else begin
            for (int w = 0; w < NWP; w++) begin
                int a;
                a = int'(wr_addr[w*AW +: AW]);
                if (wr_en[w] && a != 0) begin
                    m_mem[a]  = wr_data[w*XLEN +: XLEN];
                    m_pend[a] = 0;
                end
            end
            if (iss_valid && iss_addr != 0) m_pend[int'(iss_addr)] = 1;
            if (clr_req) begin
                m_run = 0;
                m_clr_cnt = 0;
                for (int i = 0; i < NREG; i++) m_pend[i] = 0;
            end
        end
    endtask

    function automatic logic [XLEN-1:0] exp_rd(input int a, input bit byp);
        logic [XLEN-1:0] v;
        if (!m_run || a == 0) return '0;
        v = m_mem[a];
        if (byp)
            for (int w = 0; w < NWP; w++)
                if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) v = wr_data[w*XLEN +: XLEN];
        return v;
    endfunction

    function automatic bit exp_pend(input int a);
        return m_run && a != 0 && m_pend[a];
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        iss_valid = 1'b0; iss_addr = '0; clr_req = 1'b0;
    endtask

    task automatic set_wr(input int p, input int a, input logic [XLEN-1:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = AW'(a);
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    // reset, then count the clear walk and read back every register
    task automatic test_reset();
        int cnt;
        set_idle();
        rd_addr = '0;
        reset = 1'b0;
        tick();
        tick();
        checks_total++;
        if (ready0 !== 1'b0 || dbg_state0 !== ST_CLEAR)
            $display("FAIL reset_state: ready=%b state=%0d, need ready=0 state=%0d", ready0, dbg_state0, ST_CLEAR);
        else checks_passed++;
        reset = 1'b1;
        cnt = 0;
        while (ready0 !== 1'b1 && cnt < NREG + 8) begin
            set_rd(0, $urandom_range(1, NREG - 1));
            set_rd(1, $urandom_range(1, NREG - 1));
            #1;
            checks_total++;
            if (rd_data0 !== '0 || rd_pending0 !== '0)
                $display("FAIL reset_outputs_zero: rd_data=%h rd_pending=%b, need 0", rd_data0, rd_pending0);
            else checks_passed++;
            tick();
            cnt++;
        end
        checks_total++;
        if (cnt != NREG) $display("FAIL reset_ready_latency: %0d cycles, need %0d", cnt, NREG);
        else checks_passed++;
        for (int i = 0; i < NREG; i++) begin
            set_rd(0, i);
            set_rd(1, NREG - 1 - i);
            #1;
            checks_total++;
            if (rd_data0 !== '0 || rd_pending0 !== '0)
                $display("FAIL reset_reg_zero x%0d: rd_data=%h pend=%b, need 0", i, rd_data0, rd_pending0);
            else checks_passed++;
        end
    endtask

    task automatic test_same_addr_write();
        set_idle();
        set_wr(0, 5, 32'hAAAA_0001);
        set_wr(1, 5, 32'h5555_0002);
        tick();
        set_idle();
        set_rd(0, 5);
        #1;
        checks_total++;
        if (rd_data0[XLEN-1:0] !== 32'h5555_0002)
            $display("FAIL same_addr_write: x5=%h, need 55550002", rd_data0[XLEN-1:0]);
        else checks_passed++;
    endtask

    task automatic test_bypass();
        set_idle();
        set_wr(0, 7, 32'h1234_5678);
        set_rd(0, 7);
        #1;
        checks_total++;
        if (rd_data0[XLEN-1:0] !== 32'h1234_5678)
            $display("FAIL bypass_on: rd_data=%h, need 12345678", rd_data0[XLEN-1:0]);
        else checks_passed++;
        checks_total++;
        if (rd_data1[XLEN-1:0] !== 32'h0)
            $display("FAIL bypass_off: rd_data=%h, need 00000000", rd_data1[XLEN-1:0]);
        else checks_passed++;
        tick();
        set_idle();
        #1;
        checks_total++;
        if (rd_data1[XLEN-1:0] !== 32'h1234_5678)
            $display("FAIL bypass_off_commit: rd_data=%h, need 12345678", rd_data1[XLEN-1:0]);
        else checks_passed++;
    endtask

    task automatic test_pending();
        set_idle();
        set_rd(1, 9);
        iss_valid = 1'b1; iss_addr = AW'(9);
        #1;
        checks_total++;
        if (rd_pending0[1] !== 1'b0)
            $display("FAIL pending_no_bypass: pend=%b, need 0", rd_pending0[1]);
        else checks_passed++;
        tick();
        set_idle();
        #1;
        checks_total++;
        if (rd_pending0[1] !== 1'b1) $display("FAIL pending_issue: pend=%b, need 1", rd_pending0[1]);
        else checks_passed++;
        iss_valid = 1'b1; iss_addr = AW'(9);
        set_wr(1, 9, 32'h0000_0099);
        tick();
        set_idle();
        #1;
        checks_total++;
        if (rd_pending0[1] !== 1'b1) $display("FAIL pending_issue_wins: pend=%b, need 1", rd_pending0[1]);
        else checks_passed++;
        set_wr(0, 9, 32'h0000_0042);
        tick();
        set_idle();
        #1;
        checks_total++;
        if (rd_pending0[1] !== 1'b0) $display("FAIL pending_write_clears: pend=%b, need 0", rd_pending0[1]);
        else checks_passed++;
    endtask

    task automatic test_x0();
        set_idle();
        set_wr(0, 0, 32'hFFFF_FFFF);
        set_wr(1, 0, 32'hFFFF_FFFF);
        iss_valid = 1'b1; iss_addr = '0;
        set_rd(0, 0);
        #1;
        checks_total++;
        if (rd_data0[XLEN-1:0] !== '0) $display("FAIL x0_bypass: rd_data=%h, need 0", rd_data0[XLEN-1:0]);
        else checks_passed++;
        tick();
        set_idle();
        #1;
        checks_total++;
        if (rd_data0[XLEN-1:0] !== '0 || rd_pending0[0] !== 1'b0)
            $display("FAIL x0_discard: rd_data=%h pend=%b, need 0/0", rd_data0[XLEN-1:0], rd_pending0[0]);
        else checks_passed++;
    endtask

    task automatic test_clear();
        int cnt;
        set_idle();
        set_wr(0, 3, 32'hDEAD_BEEF);
        tick();
        set_idle();
        set_rd(0, 3);
        #1;
        checks_total++;
        if (rd_data0[XLEN-1:0] !== 32'hDEAD_BEEF)
            $display("FAIL clear_pre: x3=%h, need deadbeef", rd_data0[XLEN-1:0]);
        else checks_passed++;
        clr_req = 1'b1;
        tick();
        set_idle();
        cnt = 0;
        while (ready0 !== 1'b1 && cnt < NREG + 8) begin
            set_wr(1, 3, 32'hFFFF_0000);
            iss_valid = 1'b1; iss_addr = AW'(3);
            clr_req = 1'b1;
            #1;
            checks_total++;
            if (rd_data0[XLEN-1:0] !== '0 || rd_pending0[0] !== 1'b0)
                $display("FAIL clear_outputs: rd_data=%h pend=%b, need 0/0", rd_data0[XLEN-1:0], rd_pending0[0]);
            else checks_passed++;
            tick();
            cnt++;
        end
        set_idle();
        #1;
        checks_total++;
        if (cnt != NREG) $display("FAIL clear_length: %0d cycles, need %0d", cnt, NREG);
        else checks_passed++;
        checks_total++;
        if (rd_data0[XLEN-1:0] !== '0 || rd_pending0[0] !== 1'b0)
            $display("FAIL clear_x3: x3=%h pend=%b, need 0/0", rd_data0[XLEN-1:0], rd_pending0[0]);
        else checks_passed++;
        // reset partway through the walk restarts the full count
        clr_req = 1'b1;
        tick();
        set_idle();
        repeat (10) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        cnt = 0;
        while (ready0 !== 1'b1 && cnt < NREG + 8) begin
            tick();
            cnt++;
        end
        checks_total++;
        if (cnt != NREG) $display("FAIL clear_reset_restart: %0d cycles, need %0d", cnt, NREG);
        else checks_passed++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            set_idle();
            for (int w = 0; w < NWP; w++)
                if ($urandom_range(0, 2) != 0) set_wr(w, $urandom_range(0, 7), $urandom);
            iss_valid = ($urandom_range(0, 2) == 0);
            iss_addr  = AW'($urandom_range(0, 7));
            clr_req   = ($urandom_range(0, 149) == 0);
            for (int p = 0; p < NRP; p++) set_rd(p, $urandom_range(0, 7));
            #1;
            for (int p = 0; p < NRP; p++) begin
                int a;
                a = int'(rd_addr[p*AW +: AW]);
                checks_total++;
                if (rd_data0[p*XLEN +: XLEN] !== exp_rd(a, 1'b1) ||
                    rd_data1[p*XLEN +: XLEN] !== exp_rd(a, 1'b0) ||
                    rd_pending0[p] !== exp_pend(a) || rd_pending1[p] !== exp_pend(a))
                    $display("FAIL random c%0d p%0d x%0d: data=%h/%h pend=%b/%b, need %h/%h pend=%b",
                             c, p, a, rd_data0[p*XLEN +: XLEN], rd_data1[p*XLEN +: XLEN],
                             rd_pending0[p], rd_pending1[p], exp_rd(a, 1'b1), exp_rd(a, 1'b0), exp_pend(a));
                else checks_passed++;
            end
            checks_total++;
            if (ready0 !== m_run || ready1 !== m_run)
                $display("FAIL random_ready c%0d: ready=%b/%b, need %b", c, ready0, ready1, m_run);
            else checks_passed++;
            tick();
        end
        set_idle();
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) begin
            m_mem[i] = 'x;
            m_pend[i] = 0;
        end
        m_run = 0;
        m_clr_cnt = 0;
        reset = 1'b0;
        rd_addr = '0;
        set_idle();
        test_reset();
        test_same_addr_write();
        test_bypass();
        test_pending();
        test_x0();
        test_clear();
        test_random();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
